// File: rtl/tron_pkg.sv
// Shared opcode, state and instruction-class definitions for the sequencer slice.
// Contents: opcode/extension fields, FSM state encodings, instruction class enum.
// Used by: instr_class_decode, mem_sequencer.
package tron_pkg;

   // Major opcode ir[15:12] and extension field ir[7:4]
   localparam logic [3:0] OP_MEM    = 4'b0100;
   localparam logic [3:0] OP_BCOND  = 4'b1100;
   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;

   // Sequencer state encoding (exported on the debug state port)
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEMRD  = 3'd3;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_NOP,
      CLS_LOAD,
      CLS_STOR,
      CLS_JUMP,
      CLS_BRANCH
   } instr_class_t;

endpackage

// File: rtl/mem_sequencer_if.sv
// Bundle between the sequencer and its neighbours (memory stage, register file, datapath).
// master: sequencer side (drives pc, fetch/data-port controls, ir, writeback strobes, debug).
// slave:  environment side (drives run, fetched instruction, read data, register values, branch result).
interface mem_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic                  run;
   logic [DATA_WIDTH-1:0] instruction;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] raddr_val;
   logic [DATA_WIDTH-1:0] rsrc_val;
   logic                  branch_taken;
   logic [DATA_WIDTH-1:0] branch_target;

   logic [DATA_WIDTH-1:0] pc;
   logic                  fetch_phase;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] ir;
   logic                  rf_we;
   logic                  rf_wsel;
   logic                  retire;
   logic [DATA_WIDTH-1:0] retired_cnt;
   logic [2:0]            state;

   modport master (
      input  run, instruction, mem_rdata, raddr_val, rsrc_val, branch_taken, branch_target,
      output pc, fetch_phase, mem_addr, mem_we, mem_wdata, ir, rf_we, rf_wsel,
             retire, retired_cnt, state
   );

   modport slave (
      output run, instruction, mem_rdata, raddr_val, rsrc_val, branch_taken, branch_target,
      input  pc, fetch_phase, mem_addr, mem_we, mem_wdata, ir, rf_we, rf_wsel,
             retire, retired_cnt, state
   );
endinterface

// File: rtl/instr_class_decode.sv
// Combinational classifier: latched instruction word -> instruction class.
// Ports: ir (in, 16) latched instruction; cls (out) decoded class.
// Unrecognised memory-group extensions fall through to ALU.
module instr_class_decode
   import tron_pkg::*;
(
   input  logic [15:0]  ir,
   output instr_class_t cls
);

   always_comb begin
      cls = CLS_ALU;
      if (ir == 16'h0000) begin
         cls = CLS_NOP;
      end else if (ir[15:12] == OP_BCOND) begin
         cls = CLS_BRANCH;
      end else if (ir[15:12] == OP_MEM) begin
         if (ir[7:4] == EXT_LOAD) begin
            cls = CLS_LOAD;
         end else if (ir[7:4] == EXT_STOR) begin
            cls = CLS_STOR;
         end else if (ir[7:4] == EXT_JCOND) begin
            cls = CLS_JUMP;
         end
      end
   end

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC(/MEMRD) sequencer owning the PC for a unified memory stage.
// Ports: clk, reset (sync, active-high); bus (master modport) carries memory, register-file,
//        branch and debug signals. Strobes are combinational from state/ir and gated by reset.
module mem_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic            clk,
   input  logic            reset,
   mem_sequencer_if.master bus
);
   import tron_pkg::*;

   logic [2:0]            state_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [DATA_WIDTH-1:0] ir_q;
   logic [DATA_WIDTH-1:0] cnt_q;
   logic [DATA_WIDTH-1:0] pc_inc;
   instr_class_t          cls;

   logic                  fetch_phase;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  rf_we;
   logic                  rf_wsel;
   logic                  retire;

   instr_class_decode u_decode (
      .ir  (ir_q),
      .cls (cls)
   );

   // Natural wrap: 16'hFFFF + 1 = 16'h0000
   assign pc_inc = pc_q + DATA_WIDTH'(1);

   // Strobes: all zero while reset is high so an aborted instruction issues no writes.
   always_comb begin
      fetch_phase = 1'b0;
      mem_addr    = '0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      rf_we       = 1'b0;
      rf_wsel     = 1'b0;
      retire      = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_FETCH: fetch_phase = bus.run;
            ST_EXEC: begin
               case (cls)
                  CLS_ALU: begin
                     rf_we  = 1'b1;
                     retire = 1'b1;
                  end
                  CLS_STOR: begin
                     // IO (addr[15]=1) and RAM stores look identical from here
                     mem_addr  = ADDR_WIDTH'(bus.raddr_val);
                     mem_wdata = bus.rsrc_val;
                     mem_we    = 1'b1;
                     retire    = 1'b1;
                  end
                  // Address presented here is registered by memory at the end of EXEC
                  CLS_LOAD: mem_addr = ADDR_WIDTH'(bus.raddr_val);
                  default:  retire = 1'b1;
               endcase
            end
            ST_MEMRD: begin
               mem_addr = ADDR_WIDTH'(bus.raddr_val);
               rf_we    = 1'b1;
               rf_wsel  = 1'b1;
               retire   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         if (retire) begin
            cnt_q <= cnt_q + DATA_WIDTH'(1);
         end
         case (state_q)
            ST_FETCH: begin
               if (bus.run) begin
                  state_q <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               ir_q    <= bus.instruction;
               state_q <= ST_EXEC;
            end
            ST_EXEC: begin
               state_q <= ST_FETCH;
               case (cls)
                  CLS_LOAD: state_q <= ST_MEMRD;
                  CLS_JUMP, CLS_BRANCH:
                     pc_q <= bus.branch_taken ? bus.branch_target : pc_inc;
                  default: pc_q <= pc_inc;
               endcase
            end
            ST_MEMRD: begin
               pc_q    <= pc_inc;
               state_q <= ST_FETCH;
            end
            default: state_q <= ST_FETCH;
         endcase
      end
   end

   assign bus.pc          = pc_q;
   assign bus.fetch_phase = fetch_phase;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_we      = mem_we;
   assign bus.mem_wdata   = mem_wdata;
   assign bus.ir          = ir_q;
   assign bus.rf_we       = rf_we;
   assign bus.rf_wsel     = rf_wsel;
   assign bus.retire      = retire;
   assign bus.retired_cnt = cnt_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a small unified memory stub (RAM + LED at addr[15]).
// Inputs change and outputs are sampled #1 after the falling clock edge.
module tb_mem_sequencer;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic [15:0] mem [0:255];
   logic [15:0] led;

   mem_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

   mem_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory stage stub: program image loaded under reset, registered fetch and read ports.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[8'h00] <= 16'h0352;  // ALU
         mem[8'h01] <= 16'h4140;  // STOR
         mem[8'h02] <= 16'h4200;  // LOAD
         mem[8'h03] <= 16'h4140;  // STOR (IO)
         mem[8'h04] <= 16'h0000;  // NOP
         mem[8'h05] <= 16'hC000;  // BRANCH
         mem[8'h06] <= 16'h40C0;  // JUMP
         mem[8'h40] <= 16'h40C0;  // JUMP
         mem[8'hFF] <= 16'h0000;  // NOP at 16'hFFFF
         led             <= 16'h0000;
         bus.instruction <= 16'h0000;
         bus.mem_rdata   <= 16'h0000;
      end else begin
         if (bus.fetch_phase) bus.instruction <= mem[bus.pc[7:0]];
         bus.mem_rdata <= mem[bus.mem_addr[7:0]];
         if (bus.mem_we) begin
            if (bus.mem_addr[15]) led <= bus.mem_wdata;
            else                  mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
         end
      end
   end

   task automatic advance(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.run = 1'b1;
      bus.raddr_val = 16'h0000;
      bus.rsrc_val = 16'h0000;
      bus.branch_taken = 1'b0;
      bus.branch_target = 16'h0000;
      advance(2);
      checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL reset_state got=%h exp=%h", bus.state, 3'd0); end
      checks++; if (bus.pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, 16'h0000); end
      checks++; if (bus.ir !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=%h", bus.ir, 16'h0000); end
      checks++; if (bus.retired_cnt !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%h exp=%h", bus.retired_cnt, 16'h0000); end
      checks++; if (bus.fetch_phase !== 1'b0) begin failures++; $display("FAIL reset_fetch got=%b exp=0", bus.fetch_phase); end
      checks++; if ({bus.mem_we, bus.rf_we, bus.rf_wsel, bus.retire} !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {bus.mem_we, bus.rf_we, bus.rf_wsel, bus.retire}); end
   endtask

   task automatic test_alu;
      reset = 1'b0;
      #1;
      checks++; if (bus.fetch_phase !== 1'b1) begin failures++; $display("FAIL alu_fetch got=%b exp=1", bus.fetch_phase); end
      advance(1);
      checks++; if (bus.state !== 3'd1) begin failures++; $display("FAIL alu_decode_state got=%h exp=1", bus.state); end
      advance(1);
      checks++; if ({bus.rf_we, bus.rf_wsel, bus.retire, bus.mem_we} !== 4'b1010) begin failures++; $display("FAIL alu_exec_strobes got=%b exp=1010", {bus.rf_we, bus.rf_wsel, bus.retire, bus.mem_we}); end
      checks++; if (bus.ir !== 16'h0352) begin failures++; $display("FAIL alu_ir got=%h exp=%h", bus.ir, 16'h0352); end
      advance(1);
      checks++; if (bus.pc !== 16'h0001) begin failures++; $display("FAIL alu_pc got=%h exp=%h", bus.pc, 16'h0001); end
      checks++; if (bus.retired_cnt !== 16'd1) begin failures++; $display("FAIL alu_cnt got=%0d exp=1", bus.retired_cnt); end
   endtask

   task automatic test_store_load;
      bus.raddr_val = 16'h0010;
      bus.rsrc_val  = 16'hBEEF;
      advance(2);
      checks++; if ({bus.mem_we, bus.retire, bus.rf_we} !== 3'b110) begin failures++; $display("FAIL stor_strobes got=%b exp=110", {bus.mem_we, bus.retire, bus.rf_we}); end
      checks++; if (bus.mem_addr !== 16'h0010) begin failures++; $display("FAIL stor_addr got=%h exp=%h", bus.mem_addr, 16'h0010); end
      checks++; if (bus.mem_wdata !== 16'hBEEF) begin failures++; $display("FAIL stor_wdata got=%h exp=%h", bus.mem_wdata, 16'hBEEF); end
      advance(1);
      checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 33'd0) begin failures++; $display("FAIL stor_one_cycle got=%b/%h/%h exp=0/0000/0000", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
      checks++; if (bus.pc !== 16'h0002) begin failures++; $display("FAIL stor_pc got=%h exp=%h", bus.pc, 16'h0002); end
      advance(2);
      checks++; if ({bus.state, bus.mem_we, bus.rf_we, bus.retire} !== 6'b010000) begin failures++; $display("FAIL load_exec got=%b exp=010000", {bus.state, bus.mem_we, bus.rf_we, bus.retire}); end
      checks++; if (bus.mem_addr !== 16'h0010) begin failures++; $display("FAIL load_exec_addr got=%h exp=%h", bus.mem_addr, 16'h0010); end
      advance(1);
      checks++; if ({bus.state, bus.rf_we, bus.rf_wsel, bus.retire} !== 6'b011111) begin failures++; $display("FAIL load_memrd got=%b exp=011111", {bus.state, bus.rf_we, bus.rf_wsel, bus.retire}); end
      checks++; if (bus.mem_addr !== 16'h0010) begin failures++; $display("FAIL load_memrd_addr got=%h exp=%h", bus.mem_addr, 16'h0010); end
      checks++; if (bus.mem_rdata !== 16'hBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=%h", bus.mem_rdata, 16'hBEEF); end
      advance(1);
      checks++; if (bus.pc !== 16'h0003) begin failures++; $display("FAIL load_pc got=%h exp=%h", bus.pc, 16'h0003); end
      checks++; if (bus.retired_cnt !== 16'd3) begin failures++; $display("FAIL load_cnt got=%0d exp=3", bus.retired_cnt); end
   endtask

   task automatic test_io_store;
      bus.raddr_val = 16'h8000;
      bus.rsrc_val  = 16'h00A5;
      advance(2);
      checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL io_we got=%b exp=1", bus.mem_we); end
      checks++; if (bus.mem_addr !== 16'h8000) begin failures++; $display("FAIL io_addr got=%h exp=%h", bus.mem_addr, 16'h8000); end
      advance(1);
      checks++; if (led !== 16'h00A5) begin failures++; $display("FAIL io_led got=%h exp=%h", led, 16'h00A5); end
      checks++; if (bus.pc !== 16'h0004) begin failures++; $display("FAIL io_pc got=%h exp=%h", bus.pc, 16'h0004); end
   endtask

   task automatic test_nop;
      advance(2);
      checks++; if ({bus.rf_we, bus.mem_we, bus.retire} !== 3'b001) begin failures++; $display("FAIL nop_strobes got=%b exp=001", {bus.rf_we, bus.mem_we, bus.retire}); end
      advance(1);
      checks++; if (bus.pc !== 16'h0005) begin failures++; $display("FAIL nop_pc got=%h exp=%h", bus.pc, 16'h0005); end
   endtask

   task automatic test_branch;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 16'h0040;
      advance(2);
      checks++; if ({bus.retire, bus.rf_we, bus.mem_we} !== 3'b100) begin failures++; $display("FAIL br_strobes got=%b exp=100", {bus.retire, bus.rf_we, bus.mem_we}); end
      advance(1);
      checks++; if (bus.pc !== 16'h0040) begin failures++; $display("FAIL br_taken_pc got=%h exp=%h", bus.pc, 16'h0040); end
      bus.branch_target = 16'h0005;
      advance(3);
      checks++; if (bus.pc !== 16'h0005) begin failures++; $display("FAIL jump_pc got=%h exp=%h", bus.pc, 16'h0005); end
      bus.branch_taken  = 1'b0;
      bus.branch_target = 16'h0040;
      advance(3);
      checks++; if (bus.pc !== 16'h0006) begin failures++; $display("FAIL br_not_taken_pc got=%h exp=%h", bus.pc, 16'h0006); end
      checks++; if (bus.retired_cnt !== 16'd8) begin failures++; $display("FAIL br_cnt got=%0d exp=8", bus.retired_cnt); end
   endtask

   task automatic test_wrap_and_hold;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 16'hFFFF;
      advance(3);
      checks++; if (bus.pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_jump_pc got=%h exp=%h", bus.pc, 16'hFFFF); end
      bus.branch_taken = 1'b0;
      advance(3);
      checks++; if (bus.pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc, 16'h0000); end
      checks++; if (bus.retired_cnt !== 16'd10) begin failures++; $display("FAIL wrap_cnt got=%0d exp=10", bus.retired_cnt); end
      bus.run = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if ({bus.state, bus.fetch_phase, bus.pc} !== 20'h00000) begin failures++; $display("FAIL hold_%0d got=%h/%b/%h exp=0/0/0000", i, bus.state, bus.fetch_phase, bus.pc); end
         advance(1);
      end
   endtask

   task automatic test_reset_in_memrd;
      bus.run = 1'b1;
      advance(3);
      checks++; if (bus.pc !== 16'h0001) begin failures++; $display("FAIL rerun_alu_pc got=%h exp=%h", bus.pc, 16'h0001); end
      advance(5);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (bus.state !== 3'd3) begin failures++; $display("FAIL abort_in_memrd got=%h exp=3", bus.state); end
      checks++; if ({bus.rf_we, bus.rf_wsel, bus.retire, bus.mem_we} !== 4'b0000) begin failures++; $display("FAIL abort_strobes got=%b exp=0000", {bus.rf_we, bus.rf_wsel, bus.retire, bus.mem_we}); end
      advance(1);
      checks++; if ({bus.state, bus.pc, bus.ir, bus.retired_cnt} !== 51'd0) begin failures++; $display("FAIL abort_regs got=%h/%h/%h/%h exp=0/0000/0000/0000", bus.state, bus.pc, bus.ir, bus.retired_cnt); end
      reset = 1'b0;
      #1;
      checks++; if ({bus.fetch_phase, bus.pc} !== 17'h10000) begin failures++; $display("FAIL post_reset_fetch got=%b/%h exp=1/0000", bus.fetch_phase, bus.pc); end
      advance(1);
      checks++; if (bus.instruction !== 16'h0352) begin failures++; $display("FAIL post_reset_instr got=%h exp=%h", bus.instruction, 16'h0352); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_alu();
      test_store_load();
      test_io_store();
      test_nop();
      test_branch();
      test_wrap_and_hold();
      test_reset_in_memrd();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multi-cycle control sequencer that drives the unified instruction/data memory stage. It owns the program counter and generates the fetch strobe, the data-port address, write enable and write data. It latches the fetched instruction and issues register-file write strobes for ALU results and load data. It sits directly upstream of the memory stage and consumes that stage's `instruction` and `dataOut1` outputs.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of data, instruction and PC
- `ADDR_WIDTH`, 16, memory address width (equal to `DATA_WIDTH`)

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `run`  in  1  permit a new fetch; sampled only in FETCH
- `instruction`  in  16  fetched word from memory stage, valid the cycle after `fetch_phase`
- `mem_rdata`  in  16  data-port read value (`dataOut1`), valid the cycle after the address is presented
- `raddr_val`  in  16  register-file value of `ir[3:0]` (address register)
- `rsrc_val`  in  16  register-file value of `ir[11:8]` (store source)
- `branch_taken`  in  1  datapath condition result, valid in EXEC
- `branch_target`  in  16  datapath target address, valid in EXEC
- `pc`  out  16  program counter → memory `ProgramCounter`
- `fetch_phase`  out  1  → memory `fetchPhase`
- `mem_addr`  out  16  → memory `addr1`
- `mem_we`  out  1  → memory `we1`
- `mem_wdata`  out  16  → memory `dataIn1`
- `ir`  out  16  latched instruction
- `rf_we`  out  1  register-file write strobe
- `rf_wsel`  out  1  writeback source: 0 = ALU, 1 = `mem_rdata`
- `retire`  out  1  one-cycle pulse per completed instruction
- `retired_cnt`  out  16  count of retired instructions, wraps
- `state`  out  3  current state, for debug

## Operation
Instruction classes are decoded from `ir`:
- LOAD: `ir[15:12]=4'b0100`, `ir[7:4]=4'b0000`
- STOR: `ir[15:12]=4'b0100`, `ir[7:4]=4'b0100`
- JUMP: `ir[15:12]=4'b0100`, `ir[7:4]=4'b1100`
- BRANCH: `ir[15:12]=4'b1100`
- NOP: `ir=16'h0000`
- ALU: everything else

States:
- FETCH
  - If `run`=1: `fetch_phase`=1 → DECODE.
  - If `run`=0: `fetch_phase`=0, stay in FETCH.
- DECODE: `ir <= instruction` → EXEC.
- EXEC
  - ALU: `rf_we`=1, `rf_wsel`=0, `pc<=pc+1`, retire → FETCH.
  - NOP: no strobes, `pc<=pc+1`, retire → FETCH.
  - STOR: `mem_addr=raddr_val`, `mem_wdata=rsrc_val`, `mem_we`=1, `pc<=pc+1`, retire → FETCH.
  - LOAD: `mem_addr=raddr_val`, `mem_we`=0 → MEMRD.
  - JUMP/BRANCH: `pc <= branch_taken ? branch_target : pc+1`, retire → FETCH.
- MEMRD: `mem_addr=raddr_val` held, `rf_we`=1, `rf_wsel`=1, `pc<=pc+1`, retire → FETCH.

Arithmetic and addressing rules:
- `pc+1` is modulo 2^16, so `16'hFFFF` increments to `16'h0000`.
- Stores with `mem_addr[15]`=1 are IO writes (LED). The sequencer handles them identically to RAM stores.
- `mem_addr`=0 and `mem_wdata`=0 outside EXEC/MEMRD.
- `retired_cnt` increments on each `retire`.

## Timing
- Strobes (`fetch_phase`, `mem_we`, `rf_we`, `rf_wsel`, `retire`) are combinational from `state`/`ir`. All are forced to 0 while `reset`=1.
- Registered state: `state`, `pc`, `ir`, `retired_cnt`.
- Reset values: `state`=FETCH, `pc`=0, `ir`=0, `retired_cnt`=0. All outputs 0.
- Reset mid-instruction (any state) aborts the instruction. No write strobe is issued in that cycle, and the first post-reset fetch is from address 0.
- Latency:
  - ALU/NOP/STOR/JUMP/BRANCH: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD: 4 cycles.
- Memory read timing: the memory registers the address at the end of EXEC, so `mem_rdata` is valid in MEMRD.
- A store at EXEC is committed on that edge. A LOAD of the same address by the next instruction returns the new value.
- `run` deasserted outside FETCH has no effect; the current instruction completes.

## Structure
- Shared package `tron_pkg`:
  - Opcode/ext constants (`OP_MEM=4'b0100`, `EXT_LOAD`, `EXT_STOR`, `EXT_JCOND`, `OP_BCOND=4'b1100`)
  - State encoding (FETCH=0, DECODE=1, EXEC=2, MEMRD=3)
  - Instruction-class enum
- One sub-module: `instr_class_decode` (combinational `ir` → class).
- FSM, PC and counter live in `mem_sequencer`.

## Test plan
- Reset, `run`=1, memory holding ALU word `16'h0352` at address 0: `fetch_phase` in cycle 0, `rf_we`=1/`rf_wsel`=0 in cycle 2, `pc`=1, `retired_cnt`=1.
- STOR, `raddr_val=16'h0010`, `rsrc_val=16'hBEEF`: `mem_we`=1, `mem_addr=16'h0010`, `mem_wdata=16'hBEEF` for exactly one cycle. A following LOAD from `16'h0010` gives `rf_we`=1, `rf_wsel`=1, with `mem_rdata=16'hBEEF` in MEMRD.
- STOR with `raddr_val=16'h8000`, `rsrc_val=16'h00A5`: `mem_we` pulse and `mem_addr=16'h8000`; the memory stage's LED becomes `16'h00A5`.
- BRANCH at `pc=5`: with `branch_taken`=1 and `branch_target=16'h0040`, `pc`=`16'h0040`. With `branch_taken`=0, `pc`=6.
- `pc=16'hFFFF` executing a NOP: `pc` wraps to `16'h0000`. `run`=0 holds FETCH with `fetch_phase`=0 and `pc` unchanged.
- `reset` asserted in MEMRD: no `rf_we`. Next cycle `state`=FETCH, `pc`=0, `ir`=0.
